// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory controller.
// Holds the RV32 load/store funct3 codes, the sweep FSM states and the access size type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for sub-word accesses: store mask/data placement and
// load lane extraction with sign/zero extension, plus funct3/alignment legality.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        bad
);

  size_t       sz;
  logic        legal;
  logic        misalign;
  logic        sext;
  logic [31:0] shifted;

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    sz         = SZ_WORD;
    legal      = 1'b0;
    wmask      = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rword;
    sext       = ~funct3[2];
    shifted    = rword >> {addr_lo, 3'b000};

    unique case (funct3)
      F3_B:    begin sz = SZ_BYTE; legal = 1'b1; end
      F3_H:    begin sz = SZ_HALF; legal = 1'b1; end
      F3_W:    begin sz = SZ_WORD; legal = 1'b1; end
      F3_BU:   begin sz = SZ_BYTE; legal = ~we;  end
      F3_HU:   begin sz = SZ_HALF; legal = ~we;  end
      default: begin sz = SZ_WORD; legal = 1'b0; end
    endcase

    misalign = ((sz == SZ_HALF) && addr_lo[0]) ||
               ((sz == SZ_WORD) && (addr_lo != 2'b00));

    // Store data is replicated across lanes; the mask picks which lanes land.
    case (sz)
      SZ_BYTE: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        wmask      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
    endcase

    bad = ~legal | misalign;
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: reset-time init sweep, byte/half/word loads and stores,
// fault reporting and an in-order response pipeline of READ_LAT (1 or 2) cycles.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  state_t           state, state_nx;
  logic [IDX_W-1:0] cnt;

  logic             accept;
  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic             lane_bad;
  logic             fault;
  logic [3:0]       wmask;
  logic [31:0]      wdata_lane;
  logic [31:0]      ld_data;

  logic             s1_valid, s1_fault;
  logic [31:0]      s1_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (cnt == IDX_W'(DEPTH - 1)) state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  assign req_ready = (state == S_RUN);
  assign init_done = (state == S_RUN);
  assign accept    = req_valid & req_ready;

  assign idx          = req_addr[IDX_W+1:2];
  assign out_of_range = |(req_addr >> (IDX_W + 2));
  assign fault        = out_of_range | lane_bad;

  dmem_lane_align u_align (
    .we         (req_we),
    .addr_lo    (req_addr[1:0]),
    .funct3     (req_funct3),
    .wdata      (req_wdata),
    .rword      (mem[idx]),
    .wmask      (wmask),
    .wdata_lane (wdata_lane),
    .rdata_ext  (ld_data),
    .bad        (lane_bad)
  );

  // NOTE: the array has no reset branch; the init sweep defines its contents after every reset.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[cnt] <= (INIT_MODE != 0) ? 32'(cnt) : 32'h0;
    end else if (accept && req_we && !fault) begin
      for (int b = 0; b < 4; b++)
        if (wmask[b]) mem[idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fault <= 1'b0;
      s1_rdata <= '0;
    end else begin
      s1_valid <= accept;
      s1_fault <= accept & fault;
      s1_rdata <= (accept && !req_we && !fault) ? ld_data : 32'h0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid <= 1'b0;
          rsp_fault <= 1'b0;
          rsp_rdata <= '0;
        end else begin
          rsp_valid <= s1_valid;
          rsp_fault <= s1_fault;
          rsp_rdata <= s1_rdata;
        end
      end
    end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_fault = s1_fault;
      assign rsp_rdata = s1_rdata;
    end
  endgenerate

endmodule
